// File: rtl/exe_mdu.sv
// EXE-stage multi-cycle multiply/divide unit: 2-cycle split multiply, 32-cycle restoring divide.
// Define MDU_DIV_EARLY_EN to finish divides with |A| < |B| in a single cycle.
module exe_mdu #(
   parameter int DIV_CYCLES = 32
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] EXE_ResultA,
   input  logic [31:0] EXE_ResultB,
   input  logic [2:0]  EXE_MDUOp,
   input  logic        EXE_Valid,
   input  logic        EXE_Flush,
   output logic        MDU_Busy,
   output logic [31:0] MUL_Out,
   output logic        HILO_We,
   output logic [31:0] HI_Wdata,
   output logic [31:0] LO_Wdata
);
   localparam int CW = $clog2(DIV_CYCLES);
   localparam logic [2:0] OP_MUL = 3'd1, OP_MULT = 3'd2, OP_MULTU = 3'd3,
                          OP_DIV = 3'd4, OP_DIVU = 3'd5;

   typedef enum logic [2:0] {S_IDLE, S_MUL1, S_MUL2, S_DIV, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [31:0]      a_q, a_d, b_q, b_d;
   logic [31:0]      quo_q, quo_d, rem_q, rem_d;
   logic [3:0][31:0] pp_q, pp_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [31:0]      mul_out_q, mul_out_d, hi_q, hi_d, lo_q, lo_d;
   logic             hilo_we_q, hilo_we_d;

   logic        in_mul, in_div, in_sgn, start;
   logic [31:0] in_a_mag;
`ifdef MDU_DIV_EARLY_EN
   logic [31:0] in_b_mag;
`endif
   logic        sgn, a_neg, b_neg;
   logic [31:0] a_mag, b_mag;
   logic [63:0] prod_mag, prod;
   logic [32:0] rem_sh, diff;
   logic        take;
   logic [31:0] rem_nx, quo_nx, q_fin, r_fin;

   always_comb begin
      in_mul   = EXE_MDUOp inside {OP_MUL, OP_MULT, OP_MULTU};
      in_div   = EXE_MDUOp inside {OP_DIV, OP_DIVU};
      in_sgn   = EXE_MDUOp == OP_DIV;
      in_a_mag = (in_sgn && EXE_ResultA[31]) ? -EXE_ResultA : EXE_ResultA;
`ifdef MDU_DIV_EARLY_EN
      in_b_mag = (in_sgn && EXE_ResultB[31]) ? -EXE_ResultB : EXE_ResultB;
`endif
      start    = EXE_Valid && (in_mul || in_div) && !EXE_Flush && state_q == S_IDLE;

      // Multiply and divide both work on magnitudes; the sign is restored at the end.
      sgn   = op_q inside {OP_MUL, OP_MULT, OP_DIV};
      a_neg = sgn && a_q[31];
      b_neg = sgn && b_q[31];
      a_mag = a_neg ? -a_q : a_q;
      b_mag = b_neg ? -b_q : b_q;

      prod_mag = 64'(pp_q[0]) + (64'(pp_q[1]) << 16) + (64'(pp_q[2]) << 16) + {pp_q[3], 32'd0};
      prod     = (a_neg ^ b_neg) ? -prod_mag : prod_mag;

      rem_sh = {rem_q, quo_q[31]};
      diff   = rem_sh - {1'b0, b_mag};
      take   = ~diff[32];
      rem_nx = take ? diff[31:0] : rem_sh[31:0];
      quo_nx = {quo_q[30:0], take};
      // Divide-by-zero reports the raw dividend, bypassing sign correction.
      q_fin  = (b_mag == 32'd0) ? 32'hFFFF_FFFF : ((a_neg ^ b_neg) ? -quo_nx : quo_nx);
      r_fin  = (b_mag == 32'd0) ? a_q : (a_neg ? -rem_nx : rem_nx);
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      pp_d      = pp_q;
      cnt_d     = cnt_q;
      mul_out_d = mul_out_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      hilo_we_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d = EXE_MDUOp;
               a_d  = EXE_ResultA;
               b_d  = EXE_ResultB;
               if (in_mul) begin
                  state_d = S_MUL1;
               end else begin
                  state_d = S_DIV;
                  quo_d   = in_a_mag;
                  rem_d   = 32'd0;
                  cnt_d   = '0;
`ifdef MDU_DIV_EARLY_EN
                  if (in_b_mag != 32'd0 && in_a_mag < in_b_mag) begin
                     state_d   = S_DONE;
                     lo_d      = 32'd0;
                     hi_d      = EXE_ResultA;
                     hilo_we_d = 1'b1;
                  end
`endif
               end
            end
         end
         S_MUL1: begin
            if (EXE_Flush) begin
               state_d = S_IDLE;
            end else begin
               pp_d[0] = 32'(a_mag[15:0]) * 32'(b_mag[15:0]);
               pp_d[1] = 32'(a_mag[15:0]) * 32'(b_mag[31:16]);
               pp_d[2] = 32'(a_mag[31:16]) * 32'(b_mag[15:0]);
               pp_d[3] = 32'(a_mag[31:16]) * 32'(b_mag[31:16]);
               state_d = S_MUL2;
            end
         end
         S_MUL2: begin
            if (EXE_Flush) begin
               state_d = S_IDLE;
            end else begin
               mul_out_d = prod[31:0];
               hi_d      = prod[63:32];
               lo_d      = prod[31:0];
               hilo_we_d = op_q != OP_MUL;
               state_d   = S_DONE;
            end
         end
         S_DIV: begin
            if (EXE_Flush) begin
               state_d = S_IDLE;
            end else begin
               quo_d = quo_nx;
               rem_d = rem_nx;
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(DIV_CYCLES - 1)) begin
                  lo_d      = q_fin;
                  hi_d      = r_fin;
                  hilo_we_d = 1'b1;
                  state_d   = S_DONE;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q   <= S_IDLE;
         op_q      <= 3'd0;
         a_q       <= 32'd0;
         b_q       <= 32'd0;
         quo_q     <= 32'd0;
         rem_q     <= 32'd0;
         pp_q      <= '0;
         cnt_q     <= '0;
         mul_out_q <= 32'd0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         hilo_we_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         a_q       <= a_d;
         b_q       <= b_d;
         quo_q     <= quo_d;
         rem_q     <= rem_d;
         pp_q      <= pp_d;
         cnt_q     <= cnt_d;
         mul_out_q <= mul_out_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         hilo_we_q <= hilo_we_d;
      end
   end

   assign MDU_Busy = !EXE_Flush && (start || state_q inside {S_MUL1, S_MUL2, S_DIV});
   assign HILO_We  = hilo_we_q && !EXE_Flush;
   assign MUL_Out  = mul_out_q;
   assign HI_Wdata = hi_q;
   assign LO_Wdata = lo_q;
endmodule

// File: tb/tb_exe_mdu.sv
// Self-checking bench for exe_mdu: directed corner cases plus random ops against an arithmetic model.
module tb_exe_mdu;
   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [31:0] EXE_ResultA = 32'd0, EXE_ResultB = 32'd0;
   logic [2:0]  EXE_MDUOp = 3'd0;
   logic        EXE_Valid = 1'b0, EXE_Flush = 1'b0;
   logic        MDU_Busy, HILO_We;
   logic [31:0] MUL_Out, HI_Wdata, LO_Wdata;

   int ncmp = 0;
   int nfail = 0;

   localparam logic [2:0] MUL = 3'd1, MULT = 3'd2, MULTU = 3'd3, DIV = 3'd4, DIVU = 3'd5;

   always #5 clk = ~clk;

   exe_mdu dut (
      .clk(clk), .resetn(resetn),
      .EXE_ResultA(EXE_ResultA), .EXE_ResultB(EXE_ResultB),
      .EXE_MDUOp(EXE_MDUOp), .EXE_Valid(EXE_Valid), .EXE_Flush(EXE_Flush),
      .MDU_Busy(MDU_Busy), .MUL_Out(MUL_Out), .HILO_We(HILO_We),
      .HI_Wdata(HI_Wdata), .LO_Wdata(LO_Wdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo, output int nbusy);
      logic signed [63:0] ps;
      logic [63:0]        pu;
      logic [31:0]        am, bm;
      int                 sa, sb;
      hi = 32'd0; lo = 32'd0; nbusy = 3;
      if (op == MUL || op == MULT) begin
         ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
         hi = ps[63:32]; lo = ps[31:0];
      end else if (op == MULTU) begin
         pu = {32'd0, a} * {32'd0, b};
         hi = pu[63:32]; lo = pu[31:0];
      end else begin
         nbusy = 33;
         if (b == 32'd0) begin
            lo = 32'hFFFF_FFFF; hi = a;
         end else if (op == DIV) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               lo = 32'h8000_0000; hi = 32'd0;
            end else begin
               sa = a; sb = b;
               lo = 32'(sa / sb); hi = 32'(sa % sb);
            end
         end else begin
            lo = a / b; hi = a % b;
         end
         am = (op == DIV && a[31]) ? 32'd0 - a : a;
         bm = (op == DIV && b[31]) ? 32'd0 - b : b;
`ifdef MDU_DIV_EARLY_EN
         if (bm != 32'd0 && am < bm) nbusy = 1;
`else
         if (am == bm + 32'd1) nbusy = 33;
`endif
      end
   endtask

   // Called one time unit after a rising edge; returns at the same phase after DONE.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] ehi, elo;
      int          eb, nb;
      logic        we_seen;
      model(op, a, b, ehi, elo, eb);
      EXE_Valid = 1'b1; EXE_MDUOp = op; EXE_ResultA = a; EXE_ResultB = b;
      nb = 0; we_seen = 1'b0;
      #1;
      while (MDU_Busy === 1'b1 && nb < 100) begin
         nb++;
         if (HILO_We !== 1'b0) we_seen = 1'b1;
         @(posedge clk); #1;
         EXE_ResultA = $urandom; EXE_ResultB = $urandom;
         #1;
      end
      chk({tag, ".busy_cycles"}, 32'(nb), 32'(eb));
      chk({tag, ".we_while_busy"}, {31'd0, we_seen}, 32'd0);
      chk({tag, ".hilo_we"}, {31'd0, HILO_We}, {31'd0, op != MUL});
      if (op == MUL || op == MULT || op == MULTU) chk({tag, ".mul_out"}, MUL_Out, elo);
      if (op != MUL) begin
         chk({tag, ".hi"}, HI_Wdata, ehi);
         chk({tag, ".lo"}, LO_Wdata, elo);
      end
      @(posedge clk); #1;
      EXE_Valid = 1'b0; EXE_MDUOp = 3'd0;
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, ".busy"}, {31'd0, MDU_Busy}, 32'd0);
      chk({tag, ".hilo_we"}, {31'd0, HILO_We}, 32'd0);
      chk({tag, ".mul_out"}, MUL_Out, 32'd0);
      chk({tag, ".hi"}, HI_Wdata, 32'd0);
      chk({tag, ".lo"}, LO_Wdata, 32'd0);
   endtask

   initial begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;

      repeat (2) @(posedge clk);
      #1;
      chk_zero_outputs("reset");
      resetn = 1'b1;

      // Ops that must not start
      EXE_Valid = 1'b1; EXE_MDUOp = 3'd6; #1;
      chk("op6.busy", {31'd0, MDU_Busy}, 32'd0);
      EXE_MDUOp = 3'd0; #1;
      chk("none.busy", {31'd0, MDU_Busy}, 32'd0);
      EXE_MDUOp = MULT; EXE_Flush = 1'b1; #1;
      chk("flush_start.busy", {31'd0, MDU_Busy}, 32'd0);
      @(posedge clk); #1;
      EXE_Flush = 1'b0; EXE_Valid = 1'b0; #1;
      chk("flush_start.no_op", {31'd0, MDU_Busy}, 32'd0);

      run_op("mult_neg", MULT, 32'hFFFF_FFFE, 32'h0000_0003);
      run_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op("mul_max", MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op("div_neg", DIV, 32'hFFFF_FFF9, 32'd2);
      run_op("divu_zero", DIVU, 32'd7, 32'd0);
      run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("divu_big", DIVU, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("div_zero_neg", DIV, 32'hFFFF_FFF0, 32'd0);

      // Flush partway through a divide, then an immediate multiply
      EXE_Valid = 1'b1; EXE_MDUOp = DIVU; EXE_ResultA = 32'd1000; EXE_ResultB = 32'd3; #1;
      chk("flushdiv.start_busy", {31'd0, MDU_Busy}, 32'd1);
      repeat (11) begin @(posedge clk); #1; end
      EXE_Flush = 1'b1; #1;
      chk("flushdiv.busy", {31'd0, MDU_Busy}, 32'd0);
      chk("flushdiv.hilo_we", {31'd0, HILO_We}, 32'd0);
      @(posedge clk); #1;
      EXE_Flush = 1'b0;
      run_op("after_flush_multu", MULTU, 32'd3, 32'd5);

      // Flush landing on the DONE cycle suppresses the HI/LO write
      EXE_Valid = 1'b1; EXE_MDUOp = MULT; EXE_ResultA = 32'd9; EXE_ResultB = 32'd9; #1;
      repeat (3) begin @(posedge clk); #1; end
      EXE_Flush = 1'b1; #1;
      chk("flushdone.hilo_we", {31'd0, HILO_We}, 32'd0);
      chk("flushdone.busy", {31'd0, MDU_Busy}, 32'd0);
      @(posedge clk); #1;
      EXE_Flush = 1'b0; EXE_Valid = 1'b0; EXE_MDUOp = 3'd0;

      // Reset in the middle of a divide
      EXE_Valid = 1'b1; EXE_MDUOp = DIV; EXE_ResultA = 32'h1234_5678; EXE_ResultB = 32'd5; #1;
      repeat (21) begin @(posedge clk); #1; end
      resetn = 1'b0; EXE_Valid = 1'b0; EXE_MDUOp = 3'd0;
      @(posedge clk); #1;
      chk_zero_outputs("midreset");
      resetn = 1'b1;
      run_op("divu_100_7", DIVU, 32'd100, 32'd7);

      for (int i = 0; i < 24; i++) begin
         rop = 3'($urandom_range(1, 5));
         ra  = $urandom;
         rb  = $urandom;
         case ($urandom_range(0, 3))
            0: rb = 32'($urandom_range(0, 9));
            1: ra = 32'($urandom_range(0, 50));
            2: rb = 32'd0 - 32'($urandom_range(1, 9));
            default: ;
         endcase
         run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule

// File: doc/exe_mdu.md
Name: exe_mdu

Overview:
- Multi-cycle multiply/divide unit in the EXE stage, operating alongside the ALU.
- Takes the same forwarded EXE operands. Produces the low product word that the ALU muxes out for MUL, plus HI/LO write data for MULT/MULTU/DIV/DIVU.
- Stalls the pipeline through a busy signal while an operation is in flight.

Parameters:
- DIV_CYCLES, 32, number of radix-2 restoring-divide iterations. Fixed at 32 for 32-bit operands.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- resetn  input  1  synchronous active-low reset
- EXE_ResultA  input  32  operand A: multiplicand or dividend
- EXE_ResultB  input  32  operand B: multiplier or divisor
- EXE_MDUOp  input  3  0=NONE, 1=MUL, 2=MULT, 3=MULTU, 4=DIV, 5=DIVU; 6,7 are treated as NONE
- EXE_Valid  input  1  EXE holds a valid instruction carrying EXE_MDUOp
- EXE_Flush  input  1  EXE instruction cancelled (exception or redirect)
- MDU_Busy  output  1  stall request to the pipeline control
- MUL_Out  output  32  low 32 bits of the signed product, valid in DONE for MUL
- HILO_We  output  1  one-cycle HI/LO write enable
- HI_Wdata  output  32  product high word, or remainder
- LO_Wdata  output  32  product low word, or quotient

Behaviour:
- States: IDLE, MUL1, MUL2, DIV, DONE. Reset (resetn=0 at a clock edge) forces IDLE.
- All registered outputs reset to 0: MUL_Out, HI_Wdata, LO_Wdata, HILO_We. Applies also when reset occurs mid-operation; the in-flight result is discarded.
- Start:
  - start = EXE_Valid && op!=NONE && !EXE_Flush && state==IDLE.
  - On start, latch the operands and op.
  - Multiply ops go to MUL1. Divide ops go to DIV with iteration counter = 0.
- MDU_Busy is combinational:
  - 1 when start is true.
  - 1 in MUL1, MUL2 and DIV.
  - 0 in IDLE (no start) and in DONE.
  - EXE_Flush forces MDU_Busy=0 in the same cycle.
- Multiply:
  - MUL and MULT use a signed 32x32 multiply; MULTU uses unsigned. Full 64-bit result.
  - MUL1 registers four 16x16 partial products. MUL2 sums them into a 64-bit register.
  - Then DONE.
  - Latency: start at cycle T; busy in T, T+1, T+2; DONE at T+3.
- Divide:
  - DIV converts both operands to magnitudes; DIVU uses them as-is.
  - One restoring iteration per cycle; counter runs 0..31.
  - After iteration 31, apply sign correction: quotient negated if signA^signB; remainder takes the dividend's sign. Then DONE.
  - Latency: start T, busy T..T+32, DONE at T+33.
- Divide corner cases:
  - Divisor == 0: quotient = 0xFFFFFFFF, remainder = dividend (raw). Full latency still applies.
  - DIV 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0. No exception.
- DONE (exactly one cycle), then IDLE unconditionally:
  - MUL_Out = product[31:0].
  - For MULT/MULTU/DIV/DIVU: HILO_We=1, HI_Wdata/LO_Wdata valid.
  - For MUL: HILO_We=0.
  - The stalled instruction advances in this cycle because Busy=0; it is not restarted.
  - HILO_We is 0 in every state other than DONE.
- Flush:
  - EXE_Flush in MUL1, MUL2, DIV or DONE returns the unit to IDLE on the next edge.
  - HILO_We=0 in that cycle; no HI/LO write.
- Back-to-back: a new MDU op presented in the cycle after DONE is accepted (state is IDLE).
- EXE_ResultA/B changes while busy are ignored; the latched copies are used.

Optional Feature:
- Macro MDU_DIV_EARLY_EN.
- Defined:
  - When a DIV/DIVU start has |A| < |B| (magnitudes per signedness, divisor nonzero), skip iteration.
  - Go straight to DONE: quotient 0, remainder = A (raw).
  - Latency: busy in T only, DONE at T+1.
- Undefined: all divides take the full 33 busy cycles.

Test Plan:
- MULT A=0xFFFFFFFE (-2), B=0x00000003 -> busy 3 cycles; DONE: HI=0xFFFFFFFF, LO=0xFFFFFFFA, HILO_We=1.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. MUL same operands -> MUL_Out=0x00000001, HILO_We=0.
- DIV A=0xFFFFFFF9 (-7), B=2 -> busy 33 cycles; DONE: LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=0 -> LO=0xFFFFFFFF, HI=7.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU 0x80000000 / 0xFFFFFFFF -> LO=0, HI=0x80000000 (full latency without macro; 1 cycle with MDU_DIV_EARLY_EN).
- DIVU started, EXE_Flush at iteration 10 -> Busy=0 that cycle, IDLE next, no HILO_We. Immediate following MULTU 3x5 -> LO=15 at T+3.
- resetn=0 during DIV iteration 20 -> IDLE, all outputs 0, Busy=0. After release, DIVU 100/7 -> LO=14, HI=2.
